// File: rtl/mem_stage_unit.sv
// Purpose : M pipeline stage. Runs the data-memory req/ack access and holds the MEM/WB register.
// Latency : ALU ops take 1 cycle. Aligned loads and stores take at least 3 cycles (IDLE, BUSY, DONE).
// Backpres: stallM freezes upstream until the ack arrives. A misaligned access faults without stalling.
//
// Ports:
//   clk, rst (async, active-low)
//   EX/MEM in : regWriteM, memToRegM, memWriteM, aluOutM, writeDataM, writeRegM
//   dmem bus  : dmem_req/dmem_we/dmem_addr/dmem_wdata out; dmem_ack/dmem_rdata in
//   hazard    : stallM out
//   MEM/WB out: regWriteW, memToRegW, aluOutW, readDataW, writeRegW, memFaultW
// Optional  : define MEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYC cycles without an ack.
module mem_stage_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteM,
  input  logic              memToRegM,
  input  logic              memWriteM,
  input  logic [DATA_W-1:0] aluOutM,
  input  logic [DATA_W-1:0] writeDataM,
  input  logic [REG_AW-1:0] writeRegM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stallM,
  output logic              regWriteW,
  output logic              memToRegW,
  output logic [DATA_W-1:0] aluOutW,
  output logic [DATA_W-1:0] readDataW,
  output logic [REG_AW-1:0] writeRegW,
  output logic              memFaultW
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state, stateNext;
  logic              acc, misaligned, startAcc, toHit;
  logic [DATA_W-1:0] addrQ, wdataQ, rdataQ;
  logic              weQ, timedOutQ;

  assign acc        = memToRegM | memWriteM;
  assign misaligned = acc & (aluOutM[1:0] != 2'b00);
  assign startAcc   = acc & ~misaligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] toCnt;

  // Counter value k means k+1 BUSY cycles have elapsed by the end of this one.
  // A same-cycle ack takes priority, so the timeout is masked by it.
  assign toHit = (state == BUSY) && !dmem_ack && (toCnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                toCnt <= '0;
    else if (state != BUSY)  toCnt <= '0;
    else                     toCnt <= toCnt + 1'b1;
  end
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYC != 0);
  assign toHit = 1'b0;
`endif

  // The bus is driven only in BUSY, from latched copies, so the request is
  // stable for its whole duration regardless of what EX/MEM presents.
  assign dmem_req   = (state == BUSY);
  assign dmem_we    = (state == BUSY) & weQ;
  assign dmem_addr  = addrQ;
  assign dmem_wdata = wdataQ;

  // Gated by reset so the freeze request drops immediately, even while EX/MEM
  // still presents a memory op in IDLE.
  assign stallM = rst & ((state == BUSY) | ((state == IDLE) & startAcc));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startAcc) stateNext = BUSY;
      BUSY:    if (dmem_ack || toHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Access latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ     <= '0;
      wdataQ    <= '0;
      weQ       <= 1'b0;
      rdataQ    <= '0;
      timedOutQ <= 1'b0;
    end else begin
      if ((state == IDLE) && startAcc) begin
        addrQ     <= aluOutM;
        wdataQ    <= writeDataM;
        weQ       <= memWriteM;   // load+store together is treated as a store
        timedOutQ <= 1'b0;
      end
      if (state == BUSY) begin
        if (dmem_ack && !weQ) rdataQ <= dmem_rdata;
        if (toHit)            timedOutQ <= 1'b1;
      end
    end
  end

  // MEM/WB register. A bubble clears only the control bits; the data fields hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteW <= 1'b0;
      memToRegW <= 1'b0;
      aluOutW   <= '0;
      readDataW <= '0;
      writeRegW <= '0;
      memFaultW <= 1'b0;
    end else begin
      memFaultW <= 1'b0;
      case (state)
        IDLE: begin
          if (!acc) begin
            regWriteW <= regWriteM;
            memToRegW <= memToRegM;
            aluOutW   <= aluOutM;
            writeRegW <= writeRegM;
          end else begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            if (misaligned) memFaultW <= 1'b1;
          end
        end
        BUSY: begin
          regWriteW <= 1'b0;
          memToRegW <= 1'b0;
        end
        DONE: begin
          if (timedOutQ) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            memFaultW <= 1'b1;
          end else begin
            // EX/MEM is still frozen in DONE, so the M inputs belong to this access.
            regWriteW <= regWriteM & ~weQ;
            memToRegW <= memToRegM & ~weQ;
            aluOutW   <= aluOutM;
            writeRegW <= writeRegM;
            if (!weQ) readDataW <= rdataQ;
          end
        end
        default: begin
          regWriteW <= 1'b0;
          memToRegW <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regWriteM = 1'b0, memToRegM = 1'b0, memWriteM = 1'b0;
  logic [31:0] aluOutM = '0, writeDataM = '0;
  logic [4:0]  writeRegM = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stallM, regWriteW, memToRegW, memFaultW;
  logic [31:0] aluOutW, readDataW;
  logic [4:0]  writeRegW;

  int total = 0;
  int bad   = 0;

  mem_stage_unit #(.DATA_W(32), .REG_AW(5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
    .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stallM(stallM),
    .regWriteW(regWriteW), .memToRegW(memToRegW), .aluOutW(aluOutW),
    .readDataW(readDataW), .writeRegW(writeRegW), .memFaultW(memFaultW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setNop();
    regWriteM = 1'b0; memToRegM = 1'b0; memWriteM = 1'b0;
    aluOutM = '0; writeDataM = '0; writeRegM = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    setNop();
    #3;
    total++; if (regWriteW !== 1'b0) begin bad++; $display("FAIL reset_regWriteW got %b want 0", regWriteW); end
    total++; if (memToRegW !== 1'b0) begin bad++; $display("FAIL reset_memToRegW got %b want 0", memToRegW); end
    total++; if (aluOutW !== 32'h0) begin bad++; $display("FAIL reset_aluOutW got %h want 0", aluOutW); end
    total++; if (readDataW !== 32'h0) begin bad++; $display("FAIL reset_readDataW got %h want 0", readDataW); end
    total++; if (writeRegW !== 5'd0) begin bad++; $display("FAIL reset_writeRegW got %0d want 0", writeRegW); end
    total++; if (memFaultW !== 1'b0) begin bad++; $display("FAIL reset_memFaultW got %b want 0", memFaultW); end
    total++; if (dmem_req !== 1'b0 || stallM !== 1'b0) begin bad++; $display("FAIL reset_req_stall got %b%b want 00", dmem_req, stallM); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    regWriteM = 1'b1; aluOutM = 32'h1234; writeRegM = 5'd5;
    #1;
    total++; if (stallM !== 1'b0) begin bad++; $display("FAIL alu_stall_pre got %b want 0", stallM); end
    step();
    total++; if (aluOutW !== 32'h1234) begin bad++; $display("FAIL alu_aluOutW got %h want 00001234", aluOutW); end
    total++; if (writeRegW !== 5'd5) begin bad++; $display("FAIL alu_writeRegW got %0d want 5", writeRegW); end
    total++; if (regWriteW !== 1'b1) begin bad++; $display("FAIL alu_regWriteW got %b want 1", regWriteW); end
    total++; if (stallM !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL alu_stall_post got %b%b want 00", stallM, dmem_req); end
    setNop();
  endtask

  task automatic test_load();
    int stallCnt;
    stallCnt = 0;
    regWriteM = 1'b1; memToRegM = 1'b1; aluOutM = 32'h40; writeRegM = 5'd7;
    #1;
    if (stallM) stallCnt++;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL load_req_idle got %b want 0", dmem_req); end
    step();
    if (stallM) stallCnt++;
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin bad++; $display("FAIL load_req_we got %b%b want 10", dmem_req, dmem_we); end
    total++; if (dmem_addr !== 32'h40) begin bad++; $display("FAIL load_addr got %h want 00000040", dmem_addr); end
    total++; if (regWriteW !== 1'b0) begin bad++; $display("FAIL load_bubble got %b want 0", regWriteW); end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    if (stallM) stallCnt++;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL load_req_done got %b want 0", dmem_req); end
    total++; if (stallCnt != 2) begin bad++; $display("FAIL load_stall_cycles got %0d want 2", stallCnt); end
    step();
    total++; if (readDataW !== 32'hDEADBEEF) begin bad++; $display("FAIL load_readDataW got %h want deadbeef", readDataW); end
    total++; if (memToRegW !== 1'b1 || regWriteW !== 1'b1) begin bad++; $display("FAIL load_ctrl got %b%b want 11", memToRegW, regWriteW); end
    total++; if (writeRegW !== 5'd7) begin bad++; $display("FAIL load_writeRegW got %0d want 7", writeRegW); end
    setNop();
  endtask

  task automatic test_store();
    int reqCnt;
    int badStable;
    reqCnt = 0; badStable = 0;
    memWriteM = 1'b1; aluOutM = 32'h80; writeDataM = 32'hA5A5A5A5; writeRegM = 5'd9;
    step();
    for (int i = 0; i < 5; i++) begin
      // Wiggle the M inputs to prove the bus comes from latched copies.
      aluOutM = 32'h0F00; writeDataM = 32'h0;
      #1;
      if (dmem_req) reqCnt++;
      if (dmem_we !== 1'b1 || dmem_addr !== 32'h80 || dmem_wdata !== 32'hA5A5A5A5 || regWriteW !== 1'b0) badStable++;
      aluOutM = 32'h80; writeDataM = 32'hA5A5A5A5;
      if (i == 4) dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
    total++; if (reqCnt != 5) begin bad++; $display("FAIL store_req_cycles got %0d want 5", reqCnt); end
    total++; if (badStable != 0) begin bad++; $display("FAIL store_stable got %0d bad cycles want 0", badStable); end
    total++; if (dmem_req !== 1'b0 || stallM !== 1'b0) begin bad++; $display("FAIL store_done got %b%b want 00", dmem_req, stallM); end
    step();
    total++; if (regWriteW !== 1'b0 || memToRegW !== 1'b0) begin bad++; $display("FAIL store_wb got %b%b want 00", regWriteW, memToRegW); end
    total++; if (readDataW !== 32'hDEADBEEF) begin bad++; $display("FAIL store_readData_hold got %h want deadbeef", readDataW); end
    setNop();
  endtask

  task automatic test_stray_ack();
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL stray_req got %b want 0", dmem_req); end
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step();
    total++; if (readDataW !== 32'hDEADBEEF) begin bad++; $display("FAIL stray_readDataW got %h want deadbeef", readDataW); end
  endtask

  task automatic test_misaligned();
    regWriteM = 1'b1; memToRegM = 1'b1; aluOutM = 32'h42; writeRegM = 5'd3;
    #1;
    total++; if (stallM !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL mis_idle got %b%b want 00", stallM, dmem_req); end
    step();
    setNop();
    total++; if (memFaultW !== 1'b1) begin bad++; $display("FAIL mis_fault got %b want 1", memFaultW); end
    total++; if (regWriteW !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL mis_wb got %b%b want 00", regWriteW, dmem_req); end
    step();
    total++; if (memFaultW !== 1'b0) begin bad++; $display("FAIL mis_fault_pulse got %b want 0", memFaultW); end
  endtask

  task automatic test_reset_busy();
    memWriteM = 1'b1; aluOutM = 32'h100; writeDataM = 32'h12345678;
    step();
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin bad++; $display("FAIL rstbusy_pre got %b%b want 11", dmem_req, dmem_we); end
    #2 rst = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || stallM !== 1'b0) begin bad++; $display("FAIL rstbusy_async got %b%b%b want 000", dmem_req, dmem_we, stallM); end
    total++; if (regWriteW !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin bad++; $display("FAIL rstbusy_clear got %b %h %h want 0 0 0", regWriteW, dmem_addr, dmem_wdata); end
    setNop();
    step();
    rst = 1'b1;
    regWriteM = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_ack = 1'b0;
    step();
    step();
    total++; if (regWriteW !== 1'b0 || readDataW !== 32'h0 || dmem_req !== 1'b0) begin bad++; $display("FAIL rstbusy_ack got %b %h %b want 0 0 0", regWriteW, readDataW, dmem_req); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int busyCnt;
    busyCnt = 0;
    regWriteM = 1'b1; memToRegM = 1'b1; aluOutM = 32'h200; writeRegM = 5'd4;
    step();
    while (dmem_req && busyCnt < 40) begin
      busyCnt++;
      step();
    end
    total++; if (busyCnt != 16) begin bad++; $display("FAIL timeout_busy_cycles got %0d want 16", busyCnt); end
    step();
    setNop();
    #1;
    total++; if (memFaultW !== 1'b1 || regWriteW !== 1'b0) begin bad++; $display("FAIL timeout_fault got %b%b want 10", memFaultW, regWriteW); end
    total++; if (stallM !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL timeout_idle got %b%b want 00", stallM, dmem_req); end
    step();
    total++; if (memFaultW !== 1'b0) begin bad++; $display("FAIL timeout_pulse got %b want 0", memFaultW); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_stray_ack();
    test_misaligned();
    test_reset_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Consumer of the EX/MEM pipeline register outputs (the M-stage control, aluOutM, writeDataM, writeRegM).
- Performs the data-memory access over a req/ack bus and holds the MEM/WB pipeline register.
- Raises stallM so the hazard unit can freeze IF/ID/EX and the EX/MEM register while a multi-cycle access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- REG_AW, 5, register-file index width.
- TIMEOUT_CYC, 16, ack-wait limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- regWriteM  in  1  from EX/MEM register
- memToRegM  in  1  load
- memWriteM  in  1  store
- aluOutM  in  DATA_W  effective address / ALU result
- writeDataM  in  DATA_W  store data
- writeRegM  in  REG_AW  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  byte address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete (single-cycle pulse)
- dmem_rdata  in  DATA_W  valid when dmem_ack=1 and dmem_we=0
- stallM  out  1  freeze request to the hazard unit
- regWriteW  out  1  MEM/WB register
- memToRegW  out  1  MEM/WB register
- aluOutW  out  DATA_W  MEM/WB register
- readDataW  out  DATA_W  MEM/WB register
- writeRegW  out  REG_AW  MEM/WB register
- memFaultW  out  1  one-cycle pulse: access aborted

Behaviour:
- Access condition: acc = memToRegM | memWriteM. If both are 1, the access is treated as a store and regWriteW is forced to 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, acc=0:
  - stallM=0.
  - MEM/WB captures regWriteM, memToRegM, aluOutM, writeRegM; readDataW holds.
  - Single-cycle latency.
- IDLE, acc=1:
  - stallM=1.
  - Latch addr = aluOutM, wdata = writeDataM, we = memWriteM.
  - MEM/WB loads a bubble (regWriteW=0, memToRegW=0).
  - Next state: BUSY.
- BUSY:
  - dmem_req=1; dmem_we, dmem_addr, dmem_wdata are driven from the latched copies and are stable for the whole request.
  - stallM=1; MEM/WB loads a bubble.
  - On dmem_ack=1: capture dmem_rdata when we=0, then go to DONE.
- DONE:
  - stallM=0, dmem_req=0.
  - MEM/WB captures control plus readDataW (a store writes the bubble values regWriteW=0, memToRegW=0).
  - Next state: IDLE. The EX/MEM register advances on the same edge.
- Minimum access: 3 cycles in M (ack on the first BUSY cycle); 2 cycles with stallM=1.
- Misaligned address (aluOutM[1:0] != 0) with acc=1:
  - No request is issued and stallM=0.
  - MEM/WB captures a bubble; memFaultW=1 for one cycle.
- dmem_ack while not in BUSY is ignored.
- dmem_req is never asserted outside BUSY.
- Reset (any time, including mid-access):
  - All W outputs and memFaultW go to 0; FSM goes to IDLE.
  - dmem_req, dmem_we, stallM deassert immediately (asynchronously); latched addr/wdata clear to 0.
  - A pending ack after reset release is ignored.
- All MEM/WB outputs are registered. stallM and dmem_* are combinational from state and registers only; stallM in IDLE additionally depends on acc and the alignment check.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With it defined:
  - A counter of width $clog2(TIMEOUT_CYC)+1 runs in BUSY and clears on entry.
  - If TIMEOUT_CYC cycles pass with no ack, the access is aborted and the FSM goes to DONE.
  - In DONE, MEM/WB captures a bubble and memFaultW pulses one cycle.
  - An ack on the same cycle as the timeout wins; no fault is raised.
- Without it: BUSY waits indefinitely, the counter logic is absent, and memFaultW is driven only by misalignment.

Test Plan:
- ALU op (acc=0, aluOutM=0x1234, writeRegM=5, regWriteM=1) -> next edge: aluOutW=0x1234, writeRegW=5, regWriteW=1, stallM never high.
- Load addr=0x40, ack on first BUSY cycle with rdata=0xDEADBEEF -> stallM high 2 cycles, dmem_we=0, dmem_addr=0x40; after DONE, readDataW=0xDEADBEEF, memToRegW=1, regWriteW=1.
- Store addr=0x80, wdata=0xA5A5A5A5, ack delayed 4 cycles -> dmem_req high 5 cycles with dmem_we=1 and stable addr/data; regWriteW=0 throughout.
- Misaligned load addr=0x42 -> no dmem_req, stallM=0, memFaultW one pulse, regWriteW=0.
- Reset asserted during BUSY -> dmem_req, stallM, regWriteW go to 0 before the next edge; ack pulse after release produces no writeback.
- With MEM_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> exactly 16 BUSY cycles, then memFaultW pulse, regWriteW=0, FSM in IDLE.
